// File: rtl/rf_wb_arbiter_if.sv
// Writeback request/response bundle between the two requesters, the arbiter and reg_file.
// The slave modport is the arbiter's view; the master modport drives requests and observes writes.
interface rf_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              a_valid;
  logic              a_ready;
  logic [ADDR_W-1:0] a_rd;
  logic [DATA_W-1:0] a_data;
  logic              l_valid;
  logic              l_ready;
  logic [ADDR_W-1:0] l_rd;
  logic [DATA_W-1:0] l_data;
  logic              reg_write;
  logic [ADDR_W-1:0] rd;
  logic [DATA_W-1:0] write_data;
  logic              busy;

  modport slave (
    input  a_valid, a_rd, a_data, l_valid, l_rd, l_data,
    output a_ready, l_ready, reg_write, rd, write_data, busy
  );

  modport master (
    output a_valid, a_rd, a_data, l_valid, l_rd, l_data,
    input  a_ready, l_ready, reg_write, rd, write_data, busy
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port between the ALU (A) and load (L) writeback
// paths: one small FIFO per requester, round-robin drain into registered write outputs.
module rf_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rf_wb_arbiter_if.slave wb
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PA    = 0;
  localparam int PL    = 1;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_L = 1'b1
  } grant_e;

  logic [1:0]        in_valid;
  logic [1:0]        ready;
  logic [1:0]        push;
  logic [1:0]        pop;
  logic [1:0]        nonempty;
  logic [ADDR_W-1:0] in_rd     [2];
  logic [DATA_W-1:0] in_data   [2];
  logic [ADDR_W-1:0] head_rd   [2];
  logic [DATA_W-1:0] head_data [2];

  assign in_valid    = {wb.l_valid, wb.a_valid};
  assign in_rd[PA]   = wb.a_rd;
  assign in_rd[PL]   = wb.l_rd;
  assign in_data[PA] = wb.a_data;
  assign in_data[PL] = wb.l_data;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fifo
      logic [ADDR_W-1:0] mem_rd   [DEPTH];
      logic [DATA_W-1:0] mem_data [DEPTH];
      logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
      logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
      logic [CNT_W-1:0]  count_q, count_d;

      // Ready depends on the registered count only, so a full FIFO refuses a push
      // even in the cycle it is being popped.
      assign ready[gi]    = (count_q != CNT_W'(DEPTH));
      assign nonempty[gi] = (count_q != '0);
      assign push[gi]     = in_valid[gi] & ready[gi];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push[gi]) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop[gi])  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push[gi] && !pop[gi]) count_d = count_q + 1'b1;
        if (!push[gi] && pop[gi]) count_d = count_q - 1'b1;
      end

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          count_q  <= count_d;
        end
      end

      always_ff @(posedge clk_i) begin
        if (push[gi]) begin
          mem_rd[wr_ptr_q]   <= in_rd[gi];
          mem_data[wr_ptr_q] <= in_data[gi];
        end
      end

      assign head_rd[gi]   = mem_rd[rd_ptr_q];
      assign head_data[gi] = mem_data[rd_ptr_q];
    end
  endgenerate

  grant_e            last_grant_q, last_grant_d;
  logic              reg_write_q, reg_write_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [ADDR_W-1:0] win_rd;
  logic [DATA_W-1:0] win_data;

  // When both FIFOs hold data, the port that did not win last time goes first.
  always_comb begin
    pop          = '0;
    last_grant_d = last_grant_q;
    if (nonempty[PA] && (!nonempty[PL] || last_grant_q == GRANT_L)) begin
      pop[PA]      = 1'b1;
      last_grant_d = GRANT_A;
    end else if (nonempty[PL]) begin
      pop[PL]      = 1'b1;
      last_grant_d = GRANT_L;
    end
  end

  assign win_rd   = pop[PL] ? head_rd[PL]   : head_rd[PA];
  assign win_data = pop[PL] ? head_data[PL] : head_data[PA];

  // Entries aimed at x0 are drained but never raise the write enable.
  always_comb begin
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    if (|pop) begin
      reg_write_d  = (win_rd != '0);
      rd_d         = win_rd;
      write_data_d = win_data;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_grant_q <= GRANT_L;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
    end
  end

  assign wb.a_ready    = ready[PA];
  assign wb.l_ready    = ready[PL];
  assign wb.reg_write  = reg_write_q;
  assign wb.rd         = rd_q;
  assign wb.write_data = write_data_q;
  assign wb.busy       = nonempty[PA] | nonempty[PL] | reg_write_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: queue-level reference model predicts each write and
// its cycle; a monitor compares every cycle's outputs and pops expected writes.
module tb_rf_wb_arbiter;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } ent_t;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clk;
  logic rst_n;

  rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .wb    (bus)
  );

  int checks = 0;
  int passes = 0;

  // stimulus queues, reference model state, expected-write scoreboard
  ent_t              stim_a[$];
  ent_t              stim_l[$];
  ent_t              mqa[$];
  ent_t              mql[$];
  exp_t              exp_q[$];
  int                gap_a = 0;
  int                gap_l = 0;
  int                cyc = 0;
  bit                a_acc = 0;
  bit                l_acc = 0;
  bit                last_l = 1;
  bit                m_rw = 0;
  logic [ADDR_W-1:0] m_rd = '0;
  logic [DATA_W-1:0] m_wd = '0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
    checks++;
    if (act === expv) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference model: FIFO queues, round-robin choice from occupancy before the edge.
  initial forever begin
    int   sa;
    int   sl;
    bit   pa;
    bit   pl;
    ent_t e;
    @(posedge clk);
    if (rst_n) begin
      cyc++;
      sa    = mqa.size();
      sl    = mql.size();
      a_acc = bus.a_valid && (sa < DEPTH);
      l_acc = bus.l_valid && (sl < DEPTH);
      pa    = (sa != 0) && ((sl == 0) || last_l);
      pl    = (sl != 0) && !pa;
      m_rw  = 1'b0;
      if (pa || pl) begin
        if (pa) begin
          e      = mqa.pop_front();
          last_l = 1'b0;
        end else begin
          e      = mql.pop_front();
          last_l = 1'b1;
        end
        m_rd = e.rd;
        m_wd = e.data;
        m_rw = (e.rd != '0);
        if (m_rw) exp_q.push_back('{cyc, e.rd, e.data});
      end
      if (a_acc) mqa.push_back('{bus.a_rd, bus.a_data});
      if (l_acc) mql.push_back('{bus.l_rd, bus.l_data});
    end
  end

  // Requester A: holds a refused request unchanged until it is accepted.
  initial forever begin
    ent_t e;
    @(negedge clk);
    if (!rst_n) begin
      bus.a_valid = 1'b0;
    end else if (!bus.a_valid || a_acc) begin
      if (stim_a.size() > 0 && $urandom_range(99) >= gap_a) begin
        e           = stim_a.pop_front();
        bus.a_valid = 1'b1;
        bus.a_rd    = e.rd;
        bus.a_data  = e.data;
      end else begin
        bus.a_valid = 1'b0;
      end
    end
  end

  initial forever begin
    ent_t e;
    @(negedge clk);
    if (!rst_n) begin
      bus.l_valid = 1'b0;
    end else if (!bus.l_valid || l_acc) begin
      if (stim_l.size() > 0 && $urandom_range(99) >= gap_l) begin
        e           = stim_l.pop_front();
        bus.l_valid = 1'b1;
        bus.l_rd    = e.rd;
        bus.l_data  = e.data;
      end else begin
        bus.l_valid = 1'b0;
      end
    end
  end

  // Monitor: per-cycle output checks plus scoreboard pop on every write.
  initial forever begin
    exp_t x;
    @(negedge clk);
    if (rst_n) begin
      chk("a_ready", bus.a_ready, mqa.size() < DEPTH);
      chk("l_ready", bus.l_ready, mql.size() < DEPTH);
      chk("reg_write", bus.reg_write, m_rw);
      chk("rd_hold", bus.rd, m_rd);
      chk("wdata_hold", bus.write_data, m_wd);
      chk("busy", bus.busy, (mqa.size() != 0) || (mql.size() != 0) || m_rw);
      if (bus.reg_write) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write", bus.reg_write, 1'b0);
        end else begin
          x = exp_q.pop_front();
          $display("write cyc=%0d rd=%0d data=%h", cyc, bus.rd, bus.write_data);
          chk("wr_rd", bus.rd, x.rd);
          chk("wr_data", bus.write_data, x.data);
          chk("wr_cycle", cyc, x.cyc);
        end
      end
    end
  end

  task automatic clear_model();
    stim_a.delete();
    stim_l.delete();
    mqa.delete();
    mql.delete();
    exp_q.delete();
    a_acc  = 1'b0;
    l_acc  = 1'b0;
    last_l = 1'b1;
    m_rw   = 1'b0;
    m_rd   = '0;
    m_wd   = '0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((stim_a.size() != 0 || stim_l.size() != 0 || bus.a_valid || bus.l_valid ||
            mqa.size() != 0 || mql.size() != 0 || bus.busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", tag}, n >= 400, 1'b0);
    repeat (2) @(negedge clk);
    chk({"sb_empty_", tag}, exp_q.size(), 0);
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    e.rd   = ($urandom_range(7) == 0) ? '0 : ADDR_W'($urandom_range(31));
    e.data = $urandom();
    return e;
  endfunction

  initial begin
    rst_n = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    chk("rst_reg_write", bus.reg_write, 1'b0);
    chk("rst_rd", bus.rd, '0);
    chk("rst_wdata", bus.write_data, '0);
    chk("rst_busy", bus.busy, 1'b0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_a_ready", bus.a_ready, 1'b1);
    chk("rst_l_ready", bus.l_ready, 1'b1);

    // single ALU write
    #1 stim_a.push_back('{ADDR_W'(3), 32'h11});
    wait_idle("single");

    // both ports streaming; L backs up and must stall
    @(negedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      stim_a.push_back('{ADDR_W'(1 + i), 32'hA000_0000 + 32'(i)});
      stim_l.push_back('{ADDR_W'(9 + i), 32'hB000_0000 + 32'(i)});
    end
    wait_idle("alternate");

    // write to x0 is consumed silently
    @(negedge clk);
    #1 stim_a.push_back('{ADDR_W'(0), 32'hDEAD});
    wait_idle("x0");

    // randomized traffic with varying request density
    for (int r = 0; r < 4; r++) begin
      gap_a = (r == 0) ? 0 : int'($urandom_range(70));
      gap_l = (r == 1) ? 0 : int'($urandom_range(70));
      for (int i = 0; i < 30; i++) begin
        stim_a.push_back(rnd_ent());
        stim_l.push_back(rnd_ent());
      end
      wait_idle("random");
    end

    // reset between edges with both FIFOs loaded
    gap_a = 0;
    gap_l = 0;
    @(negedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      stim_a.push_back('{ADDR_W'(20 + i), 32'hC000_0000 + 32'(i)});
      stim_l.push_back('{ADDR_W'(26 + i), 32'hD000_0000 + 32'(i)});
    end
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_reg_write", bus.reg_write, 1'b0);
    chk("midrst_busy", bus.busy, 1'b0);
    clear_model();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_stale", exp_q.size(), 0);

    // traffic after reset still works
    #1 stim_l.push_back('{ADDR_W'(7), 32'h7777});
    wait_idle("post_reset");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
